alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

- Multi-cycle 16×16 multiplier that computes the low `WORD_SIZE` bits of the product by driving the datapath ALU.
- Uses only the ALU's add, shift-left-1 and shift-right-1 actions, one ALU operation per cycle.
- Issues `ALUAction` codes and operands and consumes the ALU result, so it is the issuing side of the ALU's action interface.
- Sits beside the execute stage and shares the combinational `alu` instance (muxed by the `busy` output) to implement a multiply instruction without a dedicated multiplier.

## Interface
Parameters:
- `WORD_SIZE` — 16 (from `macro.v`); operand, product and ALU data width.
- `ALU_ACTION_BITS` — 4 (from `macro.v`); width of the action code.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request; sampled in IDLE only.
- `op_a` in `WORD_SIZE` — multiplicand; latched on accepted start.
- `op_b` in `WORD_SIZE` — multiplier; latched on accepted start.
- `busy` out 1 — sequencer owns the ALU; execute stage must mux ALU inputs to `alu_*`.
- `done` out 1 — one-cycle pulse; `product` valid from this cycle on.
- `product` out `WORD_SIZE` — result; held until the next accepted start.
- `alu_action` out `ALU_ACTION_BITS` — action code to the ALU.
- `alu_a` out `WORD_SIZE` — ALU operand A.
- `alu_b` out `WORD_SIZE` — ALU operand B.
- `alu_result` in `WORD_SIZE` — combinational ALU result for the current cycle's action.

## Operation
- **Registers**
  - `acc`: accumulator.
  - `m`: shifted multiplicand.
  - `q`: shifted multiplier.
  - `iter`: 5-bit iteration counter.
- **Reset values**
  - `acc`, `m`, `q`, `iter` = 0.
  - `product` = 0, `busy` = 0, `done` = 0.
  - `alu_action` = 9 (pass A), `alu_a` = 0, `alu_b` = 0.
- **IDLE**
  - Drives pass A with zero operands.
  - On `start`: `m` ← `op_a`, `q` ← `op_b`, `acc` ← 0, `iter` ← 0; go to ADD.
- **ADD**
  - `alu_action` = 0, A = `acc`, B = `q[0] ? m : 0`; `acc` ← `alu_result`.
  - Go to SHL.
- **SHL**
  - `alu_action` = 6, A = `m`; `m` ← `alu_result`.
  - Go to SHR.
- **SHR**
  - `alu_action` = 7, A = `q`; `q` ← `alu_result`.
  - Shift is logical; the MSB fills with 0.
  - `iter` ← `iter` + 1.
  - If `iter` was 15, go to DONE; else go to ADD.
- **DONE**
  - `product` ← `acc`, `done` = 1, `busy` = 0, ALU driven as in IDLE.
  - Go to IDLE the next cycle.
- **Arithmetic**
  - All wrap modulo 2^16; no overflow indication.
  - Low 16 bits are identical for signed and unsigned interpretations.
- **Boundaries**
  - `start` while not in IDLE is ignored; it is not queued.
  - `start` held high in DONE is ignored; it is accepted in the following IDLE cycle.
  - `reset` in any state returns to IDLE with all reset values on the next edge; no `done` is emitted for the aborted job.
  - `op_a`/`op_b` changes after acceptance have no effect.

## Timing
- Start is accepted at edge E0.
- `busy` = 1 from the cycle after E0 through the last ALU-op cycle; the ALU is driven in exactly these cycles.
- **Fixed mode:** ALU-op cycles 1..48; `done` in cycle 49; next start is accepted at the edge ending cycle 50 (IDLE). Latency is independent of operands.
- `product` updates on the edge entering DONE and is visible in the `done` cycle.
- **Early-exit mode** (see Configuration):
  - latency = 1 + (number of ALU ops) cycles.
  - `done` arrives in cycle 1 when `op_b` == 0.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN` **defined**:
  - ADD is skipped when `q[0]` == 0 (go directly to SHL).
  - After SHR, go to DONE when the new `q` == 0 or `iter` reached 16.
  - From IDLE, `op_b` == 0 goes directly to DONE with `product` = 0.
  - Latency is data-dependent.
- **Undefined:** fixed 16 iterations of ADD/SHL/SHR as above; constant 49-cycle latency.
- Results are identical in both modes.

## Structure
- Add to `macro.v`:
  - ALU action constants `ALU_ADD` (0), `ALU_SHL1` (6), `ALU_SHR1` (7), `ALU_PASS_A` (9).
  - Sequencer state encodings IDLE/ADD/SHL/SHR/DONE.
  - `MUL_ITERATIONS` (16).
- Single module with FSM, registers and output decode in one file; no sub-module.
- The ALU is external; the bench instantiates `alu` and wires `alu_result` back.

## Test plan
- Fixed mode, `op_a` = 3, `op_b` = 5 → `done` in cycle 49, `product` = 0x000F; `busy` high cycles 1–48.
- Early-exit mode, 3 × 5 → action sequence 0,6,7,6,7,0,6,7; `done` in cycle 9, `product` = 0x000F.
- 0x1234 × 0 → `product` = 0x0000; early-exit `done` in cycle 1; fixed-mode `done` in cycle 49.
- 0xFFFF × 0xFFFF → 0x0001; 300 × 300 → 0x5F90; 0x8000 × 2 → 0x0000 (wrap).
- `start` pulsed with new operands in cycle 10 of a running job → ignored; the original product is delivered; a new start is accepted only from IDLE.
- `reset` asserted in cycle 20 → next cycle: IDLE, `busy` = 0, `product` = 0, `alu_action` = 9; no `done` pulse; a following 7 × 6 returns 0x002A.

Source files
------------

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the shift-add multiply sequencer: ALU action codes, FSM states, widths.
package alu_mul_sequencer_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int ALU_ACTION_BITS = 4;
    localparam int MUL_ITERATIONS  = 16;
    localparam int ITER_BITS       = 5;

    localparam logic [ALU_ACTION_BITS-1:0] ALU_ADD    = 4'd0;
    localparam logic [ALU_ACTION_BITS-1:0] ALU_SHL1   = 4'd6;
    localparam logic [ALU_ACTION_BITS-1:0] ALU_SHR1   = 4'd7;
    localparam logic [ALU_ACTION_BITS-1:0] ALU_PASS_A = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result and shared-ALU signals of the multiply sequencer.
// master = the sequencer; slave = execute stage plus the ALU it borrows.
interface alu_mul_sequencer_if;
    import alu_mul_sequencer_pkg::*;

    logic                       start;
    logic [WORD_SIZE-1:0]       op_a;
    logic [WORD_SIZE-1:0]       op_b;
    logic                       busy;
    logic                       done;
    logic [WORD_SIZE-1:0]       product;
    logic [ALU_ACTION_BITS-1:0] alu_action;
    logic [WORD_SIZE-1:0]       alu_a;
    logic [WORD_SIZE-1:0]       alu_b;
    logic [WORD_SIZE-1:0]       alu_result;

    modport master (
        input  start, op_a, op_b, alu_result,
        output busy, done, product, alu_action, alu_a, alu_b
    );

    modport slave (
        output start, op_a, op_b, alu_result,
        input  busy, done, product, alu_action, alu_a, alu_b
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Purpose: 16x16 low-word multiply by sequencing add/shl1/shr1 ops on the shared execute ALU.
// Latency: 49 cycles fixed; with ALU_MUL_EARLY_EXIT_EN defined, 1 + number of ALU ops.
// Backpressure: none; start is only accepted in IDLE and is dropped (not queued) otherwise.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    alu_mul_sequencer_if.master  bus
);

    seq_state_e             state_q, state_d;
    logic [WORD_SIZE-1:0]   acc_q, acc_d;
    logic [WORD_SIZE-1:0]   m_q, m_d;
    logic [WORD_SIZE-1:0]   q_q, q_d;
    logic [ITER_BITS-1:0]   iter_q, iter_d;
    logic [WORD_SIZE-1:0]   product_q, product_d;
    logic                   last_iter;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        iter_d     = iter_q;
        product_d  = product_q;
        last_iter  = 1'b0;

        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.alu_action = ALU_PASS_A;
        bus.alu_a      = '0;
        bus.alu_b      = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    m_d    = bus.op_a;
                    q_d    = bus.op_b;
                    acc_d  = '0;
                    iter_d = '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
                    if (bus.op_b == '0) begin
                        state_d   = ST_DONE;
                        product_d = '0;
                    end else if (bus.op_b[0]) begin
                        state_d = ST_ADD;
                    end else begin
                        state_d = ST_SHL;
                    end
`else
                    state_d = ST_ADD;
`endif
                end
            end
            ST_ADD: begin
                bus.busy       = 1'b1;
                bus.alu_action = ALU_ADD;
                bus.alu_a      = acc_q;
                bus.alu_b      = q_q[0] ? m_q : '0;
                acc_d          = bus.alu_result;
                state_d        = ST_SHL;
            end
            ST_SHL: begin
                bus.busy       = 1'b1;
                bus.alu_action = ALU_SHL1;
                bus.alu_a      = m_q;
                m_d            = bus.alu_result;
                state_d        = ST_SHR;
            end
            ST_SHR: begin
                bus.busy       = 1'b1;
                bus.alu_action = ALU_SHR1;
                bus.alu_a      = q_q;
                q_d            = bus.alu_result;
                iter_d         = iter_q + 1'b1;
`ifdef ALU_MUL_EARLY_EXIT_EN
                // Once every multiplier bit has been shifted out, the remaining passes add nothing.
                last_iter = (iter_q == ITER_BITS'(MUL_ITERATIONS - 1)) || (bus.alu_result == '0);
                if (last_iter) begin
                    state_d   = ST_DONE;
                    product_d = acc_q;
                end else if (bus.alu_result[0]) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_SHL;
                end
`else
                last_iter = (iter_q == ITER_BITS'(MUL_ITERATIONS - 1));
                if (last_iter) begin
                    state_d   = ST_DONE;
                    product_d = acc_q;
                end else begin
                    state_d = ST_ADD;
                end
`endif
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.product = product_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            iter_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            iter_q    <= iter_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboarded bench for alu_mul_sequencer with a behavioural stand-in for the execute ALU.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_action)
            ALU_ADD:    bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SHL1:   bus.alu_result = {bus.alu_a[14:0], 1'b0};
            ALU_SHR1:   bus.alu_result = {1'b0, bus.alu_a[15:1]};
            ALU_PASS_A: bus.alu_result = bus.alu_a;
            default:    bus.alu_result = '0;
        endcase
    end

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  act_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected ALU action stream and latency, derived from the multiplier bits.
    task automatic model(input logic [15:0] b, output int lat);
        logic [15:0] q;
        act_q.delete();
        q = b;
`ifdef ALU_MUL_EARLY_EXIT_EN
        for (int i = 0; i < 16 && q != 16'h0; i++) begin
            if (q[0]) act_q.push_back(ALU_ADD);
            act_q.push_back(ALU_SHL1);
            act_q.push_back(ALU_SHR1);
            q = q >> 1;
        end
`else
        for (int i = 0; i < 16; i++) begin
            act_q.push_back(ALU_ADD);
            act_q.push_back(ALU_SHL1);
            act_q.push_back(ALU_SHR1);
        end
`endif
        lat = 1 + act_q.size();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_act"},  bus.alu_action, ALU_PASS_A);
        check({tag, "_a"},    bus.alu_a, 0);
        check({tag, "_b"},    bus.alu_b, 0);
    endtask

    // Entered and left at the falling edge of a cycle in which the DUT is idle or in DONE.
    task automatic job(input logic [15:0] a, input logic [15:0] b, input bit pre,
                       input int inj, input int rst_k);
        logic [15:0] ep;
        int lat;
        int nb;
        bit fin;
        int k;
        model(b, lat);
        ep = a * b;
        exp_q.push_back(ep);
        if (!pre) @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        if (pre) @(negedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
        nb  = 0;
        fin = 1'b0;
        k   = 0;
        while (!fin && k < 200) begin
            k++;
            @(negedge clk);
            if (k == inj) begin
                bus.start = 1'b1;
                bus.op_a  = 16'h7777;
                bus.op_b  = 16'h0003;
            end else if (inj > 0 && k == inj + 1) begin
                bus.start = 1'b0;
            end
            if (rst_k > 0 && k == rst_k + 1) begin
                reset = 1'b0;
                check_idle_outputs("rst");
                check("rst_product", bus.product, 0);
                void'(exp_q.pop_front());
                act_q.delete();
                fin = 1'b1;
            end else begin
                if (rst_k > 0 && k == rst_k) reset = 1'b1;
                if (bus.busy) begin
                    nb++;
                    if (act_q.size() > 0) check("action", bus.alu_action, act_q.pop_front());
                    else check("op_count", nb, lat - 1);
                end
                if (bus.done) begin
                    fin = 1'b1;
                    check("product", bus.product, exp_q.pop_front());
                    check("latency", k, lat);
                    check("busy_cycles", nb, lat - 1);
                    check("done_act", bus.alu_action, ALU_PASS_A);
                    check("done_busy", bus.busy, 0);
                end
            end
        end
        if (!fin) begin
            check("timeout", k, lat);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int ndone;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_product", bus.product, 0);
        reset = 1'b0;

        job(16'd3, 16'd5, 1'b0, 0, 0);
        check("p_3x5", bus.product, 16'h000F);
        job(16'h1234, 16'h0000, 1'b0, 0, 0);
        check("p_x0", bus.product, 16'h0000);
        job(16'hFFFF, 16'hFFFF, 1'b0, 0, 0);
        check("p_ffff", bus.product, 16'h0001);
        job(16'd300, 16'd300, 1'b0, 0, 0);
        check("p_300", bus.product, 16'h5F90);
        job(16'h8000, 16'd2, 1'b0, 0, 0);
        check("p_wrap", bus.product, 16'h0000);
        // Start pulse with other operands mid-job must be dropped.
        job(16'd3, 16'd5, 1'b0, 10, 0);
        check("p_ignored_start", bus.product, 16'h000F);
        // Start raised during DONE and held must be taken one cycle later.
        job(16'h00FF, 16'h0101, 1'b1, 0, 0);
        job(16'h0ABC, 16'h8001, 1'b1, 0, 0);

        job(16'hABCD, 16'h1357, 1'b0, 0, 20);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no_done_after_reset", ndone, 0);
        job(16'd7, 16'd6, 1'b0, 0, 0);
        check("p_7x6", bus.product, 16'h002A);

        for (int i = 0; i < 6; i++) begin
            job(16'($urandom), 16'($urandom_range(0, 255) << $urandom_range(0, 8)), 1'b0, 0, 0);
        end

        @(negedge clk);
        check_idle_outputs("final");
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
